instr_encode_loader: RTL and testbench

Sequential RISC-V instruction encoder and instruction-memory loader. It accepts field-level instruction requests over a valid/ready handshake and packs each into a 32-bit RV32I word using the same format classes the main decoder's ImmSrc distinguishes. Encoded words are buffered in a small FIFO and written to consecutive instruction-memory addresses through a stallable write port. It sits in the test/boot infrastructure and fills instruction memory ahead of CPU execution.

---
 rtl/instr_encode_loader.sv | 106 ++++++++++
 tb/tb_instr_encode_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encode_loader.sv
// instr_encode_loader: packs field-level RV32I requests into 32-bit words,
// buffers them in a small FIFO and writes them to consecutive
// instruction-memory addresses through a stallable write port.
module instr_encode_loader #(
  parameter int                    DEPTH      = 4,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'hBFC00000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Restart,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [2:0]            Fmt,
  input  logic [6:0]            Op,
  input  logic [4:0]            Rd,
  input  logic [4:0]            Rs1,
  input  logic [4:0]            Rs2,
  input  logic [2:0]            Funct3,
  input  logic [6:0]            Funct7,
  input  logic [31:0]           Imm,
  output logic                  WrEn,
  input  logic                  WrReady,
  output logic [ADDR_WIDTH-1:0] WrAddr,
  output logic [31:0]           WrData,
  output logic [15:0]           WordCount,
  output logic                  ErrInvalid
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  typedef enum logic [2:0] {
    FMT_I = 3'd0, FMT_U = 3'd1, FMT_S = 3'd2,
    FMT_B = 3'd3, FMT_J = 3'd4, FMT_R = 3'd5
  } fmt_e;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [PW:0]   cnt;
  logic [31:0]   enc;
  logic          fmt_ok, accept, push, pop;

  // Format-specific bit packing of the request fields
  always_comb begin
    enc    = 32'd0;
    fmt_ok = 1'b1;
    case (fmt_e'(Fmt))
      FMT_I: enc = {Imm[11:0], Rs1, Funct3, Rd, Op};
      FMT_U: enc = {Imm[31:12], Rd, Op};
      FMT_S: enc = {Imm[11:5], Rs2, Rs1, Funct3, Imm[4:0], Op};
      FMT_B: enc = {Imm[12], Imm[10:5], Rs2, Rs1, Funct3, Imm[4:1], Imm[11], Op};
      FMT_J: enc = {Imm[20], Imm[10:1], Imm[11], Imm[19:12], Rd, Op};
      FMT_R: enc = {Funct7, Rs2, Rs1, Funct3, Rd, Op};
      default: fmt_ok = 1'b0;
    endcase
  end

  // Handshake and write-port view; all derived from registered state only
  always_comb begin
    InReady = (cnt < DEPTH_C);
    WrEn    = (cnt != '0);
    WrData  = WrEn ? mem[rptr] : 32'd0;
    accept  = InValid && InReady;
    push    = accept && fmt_ok && !Restart;
    pop     = WrEn && WrReady && !Restart;
  end

  // FIFO storage; data needs no reset since cnt gates visibility
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= enc;
  end

  // FIFO pointers/occupancy, write address, word counter and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      cnt        <= '0;
      WrAddr     <= BASE_ADDR;
      WordCount  <= 16'd0;
      ErrInvalid <= 1'b0;
    end else if (Restart) begin
      wptr       <= '0;
      rptr       <= '0;
      cnt        <= '0;
      WrAddr     <= BASE_ADDR;
      WordCount  <= 16'd0;
      ErrInvalid <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop) begin
        rptr      <= rptr + PW'(1);
        WrAddr    <= WrAddr + ADDR_WIDTH'(4);
        WordCount <= WordCount + 16'd1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: cnt <= cnt;
      endcase
      if (accept && !fmt_ok) ErrInvalid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Bench for instr_encode_loader: queue-based reference model checked every
// cycle, directed literal checks and a randomized phase, plus a narrow-address
// instance for address wrap.
module tb_instr_encode_loader;

  localparam logic [31:0] BASE = 32'hBFC00000;

  logic        clk = 1'b0, rst_n = 1'b0, Restart = 1'b0, InValid = 1'b0, WrReady = 1'b0;
  logic [2:0]  Fmt = '0, Funct3 = '0;
  logic [6:0]  Op = '0, Funct7 = '0;
  logic [4:0]  Rd = '0, Rs1 = '0, Rs2 = '0;
  logic [31:0] Imm = '0;
  logic        InReady, WrEn, ErrInvalid;
  logic [31:0] WrAddr, WrData;
  logic [15:0] WordCount;

  logic        b_InValid = 1'b0, b_WrReady = 1'b1, b_Restart = 1'b0;
  logic        b_InReady, b_WrEn, b_ErrInvalid;
  logic [7:0]  b_WrAddr;
  logic [31:0] b_WrData;
  logic [15:0] b_WordCount;

  int vectors = 0, errs = 0;
  bit chk_en = 1'b0;

  instr_encode_loader dut (
    .clk(clk), .rst_n(rst_n), .Restart(Restart), .InValid(InValid), .InReady(InReady),
    .Fmt(Fmt), .Op(Op), .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2), .Funct3(Funct3), .Funct7(Funct7),
    .Imm(Imm), .WrEn(WrEn), .WrReady(WrReady), .WrAddr(WrAddr), .WrData(WrData),
    .WordCount(WordCount), .ErrInvalid(ErrInvalid));

  instr_encode_loader #(.DEPTH(4), .ADDR_WIDTH(8), .BASE_ADDR(8'hF8)) dut_b (
    .clk(clk), .rst_n(rst_n), .Restart(b_Restart), .InValid(b_InValid), .InReady(b_InReady),
    .Fmt(Fmt), .Op(Op), .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2), .Funct3(Funct3), .Funct7(Funct7),
    .Imm(Imm), .WrEn(b_WrEn), .WrReady(b_WrReady), .WrAddr(b_WrAddr), .WrData(b_WrData),
    .WordCount(b_WordCount), .ErrInvalid(b_ErrInvalid));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference encoder built from shifts and masks of the field values
  function automatic logic [31:0] ref_enc(input logic [2:0] f, input logic [6:0] op,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    bit [31:0] o = 32'(op), d = 32'(rd) << 7, a = 32'(rs1) << 15, b = 32'(rs2) << 20;
    bit [31:0] t = 32'(f3) << 12;
    case (f)
      3'd0: return o + d + t + a + ((imm & 32'hFFF) << 20);
      3'd1: return o + d + (imm & 32'hFFFFF000);
      3'd2: return o + ((imm & 32'h1F) << 7) + t + a + b + (((imm >> 5) & 32'h7F) << 25);
      3'd3: return o + (((imm >> 11) & 1) << 7) + (((imm >> 1) & 32'hF) << 8) + t + a + b
                   + (((imm >> 5) & 32'h3F) << 25) + (((imm >> 12) & 1) << 31);
      3'd4: return o + d + (((imm >> 12) & 32'hFF) << 12) + (((imm >> 11) & 1) << 20)
                   + (((imm >> 1) & 32'h3FF) << 21) + (((imm >> 20) & 1) << 31);
      3'd5: return o + d + t + a + b + (32'(f7) << 25);
      default: return 32'd0;
    endcase
  endfunction

  // Reference model state
  logic [31:0] mq[$];
  logic [31:0] m_addr = BASE;
  logic [15:0] m_wc = '0;
  logic        m_err = 1'b0;
  bit          m_acc, m_pop;

  // Model update at each edge; request/ready values are stable here
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || Restart) begin
      mq.delete(); m_addr = BASE; m_wc = '0; m_err = 1'b0;
    end else begin
      m_acc = InValid && (mq.size() < 4);
      m_pop = (mq.size() > 0) && WrReady;
      if (m_pop) begin void'(mq.pop_front()); m_addr += 4; m_wc++; end
      if (m_acc) begin
        if (Fmt <= 3'd5) mq.push_back(ref_enc(Fmt, Op, Rd, Rs1, Rs2, Funct3, Funct7, Imm));
        else m_err = 1'b1;
      end
    end
  end

  // Write logs: each entry is a transfer that completes at the next edge
  logic [31:0] log_a[$], log_d[$];
  logic [7:0]  b_log[$];

  // Per-cycle compare against the model, sampled mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("InReady", 32'(InReady), 32'(mq.size() < 4));
      chk("WrEn", 32'(WrEn), 32'(mq.size() != 0));
      chk("WrData", WrData, (mq.size() != 0) ? mq[0] : 32'd0);
      chk("WrAddr", WrAddr, m_addr);
      chk("WordCount", 32'(WordCount), 32'(m_wc));
      chk("ErrInvalid", 32'(ErrInvalid), 32'(m_err));
      if (rst_n && !Restart && WrEn && WrReady) begin
        log_a.push_back(WrAddr); log_d.push_back(WrData);
      end
      if (rst_n && b_WrEn && b_WrReady) b_log.push_back(b_WrAddr);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic setreq(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
    Fmt = f; Op = op; Rd = rd; Rs1 = rs1; Rs2 = rs2; Funct3 = f3; Imm = imm;
    Funct7 = 7'($urandom);
  endtask

  task automatic rnd_req(input bit allow_bad);
    Fmt = (allow_bad && $urandom_range(0, 15) == 0) ? 3'(6 + $urandom_range(0, 1))
                                                    : 3'($urandom_range(0, 5));
    Op = 7'($urandom); Rd = 5'($urandom); Rs1 = 5'($urandom); Rs2 = 5'($urandom);
    Funct3 = 3'($urandom); Funct7 = 7'($urandom); Imm = $urandom;
  endtask

  initial begin
    // Reset state
    #7;
    chk("rst InReady", 32'(InReady), 32'd1);
    chk("rst WrEn", 32'(WrEn), 32'd0);
    chk("rst WrAddr", WrAddr, BASE);
    chk("rst WrData", WrData, 32'd0);
    chk("rst WordCount", 32'(WordCount), 32'd0);
    chk("rst ErrInvalid", 32'(ErrInvalid), 32'd0);
    step(); rst_n = 1'b1; chk_en = 1'b1;

    // Directed stream I, S, B, J, U with WrReady high
    WrReady = 1'b1; log_a.delete(); log_d.delete();
    InValid = 1'b1;
    setreq(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);          step();
    setreq(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8);          step();
    setreq(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFFFFF8);   step();
    setreq(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd16);         step();
    setreq(3'd1, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000);   step();
    InValid = 1'b0;
    repeat (3) step();
    chk("dir log size", 32'(log_d.size()), 32'd5);
    if (log_d.size() == 5) begin
      chk("dir I data", log_d[0], 32'h00500093);
      chk("dir S data", log_d[1], 32'h0020A423);
      chk("dir B data", log_d[2], 32'hFE208CE3);
      chk("dir J data", log_d[3], 32'h010000EF);
      chk("dir U data", log_d[4], 32'h123452B7);
      chk("dir I addr", log_a[0], 32'hBFC00000);
      chk("dir U addr", log_a[4], 32'hBFC00010);
    end
    chk("dir WordCount", 32'(WordCount), 32'd5);

    // Backpressure: WrReady low for 10 cycles with InValid held
    WrReady = 1'b0; InValid = 1'b1;
    repeat (10) begin rnd_req(1'b0); step(); end
    chk("bp InReady", 32'(InReady), 32'd0);
    chk("bp WrEn", 32'(WrEn), 32'd1);
    chk("bp WrAddr", WrAddr, 32'hBFC00014);
    chk("bp log size", 32'(log_d.size()), 32'd5);
    InValid = 1'b0; WrReady = 1'b1;
    repeat (6) step();
    chk("bp drained", 32'(WordCount), 32'd9);

    // Invalid format then a valid request
    Fmt = 3'd7; InValid = 1'b1; step();
    InValid = 1'b0;
    chk("err set", 32'(ErrInvalid), 32'd1);
    chk("err no push", 32'(WrEn), 32'd0);
    setreq(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5); InValid = 1'b1; step();
    InValid = 1'b0; step();
    chk("err then valid", 32'(WordCount), 32'd10);

    // Restart with 3 words buffered and a request presented
    WrReady = 1'b0; InValid = 1'b1;
    repeat (3) begin rnd_req(1'b0); step(); end
    Fmt = 3'd6; step();
    rnd_req(1'b0); Restart = 1'b1; step();
    Restart = 1'b0; InValid = 1'b0;
    chk("rs WrEn", 32'(WrEn), 32'd0);
    chk("rs WrAddr", WrAddr, BASE);
    chk("rs WordCount", 32'(WordCount), 32'd0);
    chk("rs ErrInvalid", 32'(ErrInvalid), 32'd0);

    // Asynchronous reset pulse mid-stream
    WrReady = 1'b1; InValid = 1'b1;
    repeat (3) begin rnd_req(1'b0); step(); end
    WrReady = 1'b0; rnd_req(1'b0); step();
    #2 rst_n = 1'b0; #1;
    chk("ar WrEn", 32'(WrEn), 32'd0);
    chk("ar WrAddr", WrAddr, BASE);
    chk("ar WordCount", 32'(WordCount), 32'd0);
    chk("ar InReady", 32'(InReady), 32'd1);
    InValid = 1'b0;
    step(); rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      InValid = ($urandom_range(0, 3) != 0);
      rnd_req(1'b1);
      WrReady = ($urandom_range(0, 2) != 0);
      Restart = ($urandom_range(0, 99) == 0);
      step();
    end
    Restart = 1'b0; InValid = 1'b0; WrReady = 1'b1;
    repeat (6) step();

    // Narrow address instance: wrap from 0xFC to 0x00
    b_log.delete(); b_InValid = 1'b1;
    repeat (3) begin setreq(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1); step(); end
    b_InValid = 1'b0;
    repeat (3) step();
    chk("wrap count", 32'(b_log.size()), 32'd3);
    if (b_log.size() == 3) begin
      chk("wrap a0", 32'(b_log[0]), 32'hF8);
      chk("wrap a1", 32'(b_log[1]), 32'hFC);
      chk("wrap a2", 32'(b_log[2]), 32'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
